jt4701_qgen: RTL and testbench

- Upstream quadrature generator for the uPD4701A-equivalent counter.
- Converts signed movement deltas (PS/2 mouse packets, joystick/analog emulation) into rate-limited two-phase A/B quadrature on one axis.
- Instantiate one per axis; its `quad` output drives that axis's x_in/y_in (MSB=A, LSB=B).
- Positive deltas make A lead, so the downstream counter increments.

---
 rtl/jt4701_pkg.sv | 30 +++
 rtl/jt4701_qstep.sv | 76 +++++++
 rtl/jt4701_qgen.sv | 80 ++++++++
 tb/tb_jt4701_qgen.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jt4701_pkg.sv
// Shared definitions for the uPD4701A-side quadrature generator:
// gray phase encodings, step engine states and the gray stepping helper.
package jt4701_pkg;

    // Quadrature phases {A,B}, listed in increment order
    localparam logic [1:0] PH0 = 2'b00;
    localparam logic [1:0] PH1 = 2'b10;
    localparam logic [1:0] PH2 = 2'b11;
    localparam logic [1:0] PH3 = 2'b01;

    // IDLE means the spacing timer has expired and an edge may be emitted
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } qstep_state_t;

    // One gray position forward (inc=1, A leads) or backward (inc=0)
    function automatic logic [1:0] next_phase(input logic [1:0] phase, input logic inc);
        logic [1:0] r;
        r = phase;
        case (phase)
            PH0:     r = inc ? PH1 : PH3;
            PH1:     r = inc ? PH2 : PH0;
            PH2:     r = inc ? PH3 : PH1;
            default: r = inc ? PH0 : PH2;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/jt4701_qstep.sv
// Quadrature step engine: owns the quad phase register, the direction flag
// and the edge spacing timer. A step request is only issued by the parent
// while the engine reports IDLE; clr flushes the timer but keeps the phase
// so the downstream counter never sees a spurious edge.
module jt4701_qstep
    import jt4701_pkg::*;
#(
    parameter int DIV = 16
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         clr,
    input  logic         step_req,
    input  logic         step_inc,
    output logic [1:0]   quad,
    output logic         dir,
    output qstep_state_t state
);

    localparam int TW = $clog2(DIV);

    logic [TW-1:0] timer;
    logic [TW-1:0] nxt_timer;
    qstep_state_t  nxt_state;
    logic [1:0]    nxt_quad;
    logic          nxt_dir;

    // Next-state logic: clr wins, then an edge reloads the timer, else count down
    always_comb begin
        nxt_state = state;
        nxt_timer = timer;
        nxt_quad  = quad;
        nxt_dir   = dir;
        if (clr) begin
            nxt_state = ST_IDLE;
            nxt_timer = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (step_req) begin
                        nxt_quad  = next_phase(quad, step_inc);
                        nxt_dir   = step_inc;
                        nxt_timer = TW'(DIV - 1);
                        nxt_state = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    nxt_timer = timer - TW'(1);
                    if (timer == TW'(1)) begin
                        nxt_state = ST_IDLE;
                    end
                end
                default: begin
                    nxt_state = ST_IDLE;
                    nxt_timer = '0;
                end
            endcase
        end
    end

    // State, timer, phase and direction registers; reset parks at phase 00
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= ST_IDLE;
            timer <= '0;
            quad  <= PH0;
            dir   <= 1'b0;
        end else begin
            state <= nxt_state;
            timer <= nxt_timer;
            quad  <= nxt_quad;
            dir   <= nxt_dir;
        end
    end

endmodule

// File: rtl/jt4701_qgen.sv
// Delta-to-quadrature generator for one axis. Signed deltas are summed into
// a pending-step accumulator, which the step engine drains one gray edge at
// a time, no faster than one edge every DIV clocks.
//
// Handshake: a delta is taken on a rising clk edge where din_valid and
// din_ready are both high. din_ready is combinational from the registered
// accumulator and clr, and drops whenever one more full-scale delta could
// overflow the accumulator, so no saturation is ever needed.
module jt4701_qgen
    import jt4701_pkg::*;
#(
    parameter int W   = 9,
    parameter int PW  = 12,
    parameter int DIV = 16
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         din_valid,
    input  logic [W-1:0] din,
    output logic         din_ready,
    input  logic         clr,
    output logic [1:0]   quad,
    output logic         busy,
    output logic         dir
);

    // Largest |pending| that still has room for a full-scale delta
    localparam logic [PW:0] LIM = (PW+1)'((2 ** (PW - 1)) - 1 - (2 ** (W - 1)));

    logic [PW-1:0] pending;
    logic [PW-1:0] nxt_pending;
    logic [PW-1:0] delta;
    logic [PW-1:0] step;
    logic [PW:0]   pend_ext;
    logic [PW:0]   pend_abs;
    logic          accept;
    logic          step_edge;
    logic          step_inc;
    qstep_state_t  step_state;

    // One extra bit so the most negative pending value has a representable magnitude
    assign pend_ext  = {pending[PW-1], pending};
    assign pend_abs  = pending[PW-1] ? -pend_ext : pend_ext;
    assign din_ready = !clr && (pend_abs <= LIM);
    assign accept    = din_valid && din_ready;
    assign delta     = accept ? {{(PW-W){din[W-1]}}, din} : '0;

    // An edge drains one step toward zero whenever the engine is free
    assign step_inc  = !pending[PW-1];
    assign step_edge = (step_state == ST_IDLE) && (pending != '0) && !clr;
    assign step      = step_edge ? (step_inc ? PW'(1) : '1) : '0;

    // Single adder: a delta arriving in an edge cycle is not lost
    assign nxt_pending = clr ? '0 : (pending + delta - step);

    // Accumulator and busy flag registered together
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pending <= '0;
            busy    <= 1'b0;
        end else begin
            pending <= nxt_pending;
            busy    <= (nxt_pending != '0);
        end
    end

    jt4701_qstep #(
        .DIV (DIV)
    ) u_qstep (
        .clk      (clk),
        .rstn     (rstn),
        .clr      (clr),
        .step_req (step_edge),
        .step_inc (step_inc),
        .quad     (quad),
        .dir      (dir),
        .state    (step_state)
    );

endmodule

// File: tb/tb_jt4701_qgen.sv
// Directed bench for jt4701_qgen with DIV=4. A behavioural model based on
// cycle-since-last-edge arithmetic and an integer phase index is checked
// against the DUT on every falling edge; a downstream counter built from the
// quad output pins the net movement at key points.
module tb_jt4701_qgen;

    localparam int W   = 9;
    localparam int PW  = 12;
    localparam int DIV = 4;
    localparam int LIM = 1791;
    localparam logic [1:0] GRAY [4] = '{2'b00, 2'b10, 2'b11, 2'b01};

    logic         clk;
    logic         rstn;
    logic         din_valid;
    logic [W-1:0] din;
    logic         din_ready;
    logic         clr;
    logic [1:0]   quad;
    logic         busy;
    logic         dir;

    int checks   = 0;
    int failures = 0;

    jt4701_qgen #(
        .W   (W),
        .PW  (PW),
        .DIV (DIV)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .din_valid (din_valid),
        .din       (din),
        .din_ready (din_ready),
        .clr       (clr),
        .quad      (quad),
        .busy      (busy),
        .dir       (dir)
    );

    // Clock and reset-free clock generation
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int ph_of(input logic [1:0] q);
        for (int i = 0; i < 4; i++) begin
            if (GRAY[i] == q) return i;
        end
        return 0;
    endfunction

    // Behavioural model
    int m_pend;
    int m_ph;
    int m_cyc;
    int m_last;
    int m_step;
    int m_d;
    bit m_dir;
    bit m_busy;
    bit m_acc;

    function automatic bit model_ready();
        int a;
        a = (m_pend < 0) ? -m_pend : m_pend;
        return !clr && (a <= LIM);
    endfunction

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_pend = 0;
            m_ph   = 0;
            m_cyc  = 0;
            m_last = -1000;
            m_dir  = 1'b0;
            m_busy = 1'b0;
        end else begin
            m_acc = din_valid && model_ready();
            m_d   = int'($signed(din));
            if (clr) begin
                m_pend = 0;
                m_last = -1000;
            end else begin
                m_step = 0;
                if (m_pend != 0 && (m_cyc - m_last) >= DIV) begin
                    m_step = (m_pend > 0) ? 1 : -1;
                    m_ph   = (m_ph + m_step + 4) % 4;
                    m_dir  = (m_step > 0);
                    m_last = m_cyc;
                end
                m_pend = m_pend + (m_acc ? m_d : 0) - m_step;
            end
            m_busy = (m_pend != 0);
            m_cyc++;
        end
    end

    // Compare process plus downstream counter
    int         cnt = 0;
    logic [1:0] prev_q = 2'b00;
    int         dph;

    always @(negedge clk) begin
        check("quad", quad, GRAY[m_ph]);
        check("busy", busy, m_busy);
        check("dir", dir, m_dir);
        check("din_ready", din_ready, model_ready());
        check("pending", int'($signed(dut.pending)), m_pend);
        if (!rstn) begin
            cnt    = 0;
            prev_q = 2'b00;
        end else if (quad != prev_q) begin
            dph = (ph_of(quad) - ph_of(prev_q) + 4) % 4;
            if (dph == 1) cnt++;
            else if (dph == 3) cnt--;
            else check("single_bit_edge", dph, 1);
            prev_q = quad;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    bit saw_low;
    bit saw_high;
    int c0;
    int peak;

    // Directed stimulus with literal expectations
    initial begin
        rstn      = 1'b0;
        din_valid = 1'b0;
        din       = '0;
        clr       = 1'b0;
        repeat (3) tick();
        check("rst_quad", quad, 2'b00);
        check("rst_busy", busy, 0);
        check("rst_dir", dir, 0);
        check("rst_ready", din_ready, 1);
        rstn = 1'b1;
        repeat (2) tick();

        // +3: edges at c1, c5, c9
        din_valid = 1'b1;
        din       = 9'd3;
        tick();
        din_valid = 1'b0;
        tick();
        check("t1_c1_quad", quad, 2'b10);
        check("t1_c1_dir", dir, 1);
        check("t1_c1_busy", busy, 1);
        repeat (3) tick();
        check("t1_c4_quad", quad, 2'b10);
        tick();
        check("t1_c5_quad", quad, 2'b11);
        repeat (4) tick();
        check("t1_c9_quad", quad, 2'b01);
        check("t1_c9_busy", busy, 0);
        check("t1_c9_dir", dir, 1);
        tick();
        check("t1_count", cnt, 3);
        repeat (3) tick();

        // -2 from phase 01
        din_valid = 1'b1;
        din       = 9'h1FE;
        tick();
        din_valid = 1'b0;
        tick();
        check("t2_e1_quad", quad, 2'b11);
        check("t2_e1_dir", dir, 0);
        repeat (3) tick();
        check("t2_hold_quad", quad, 2'b11);
        tick();
        check("t2_e2_quad", quad, 2'b10);
        check("t2_e2_busy", busy, 0);
        tick();
        check("t2_count", cnt, 1);

        // Back-pressure with +255 streaming in
        din_valid = 1'b1;
        din       = 9'd255;
        saw_low   = 1'b0;
        saw_high  = 1'b0;
        peak      = 0;
        for (int i = 0; i < 3000 && !saw_high; i++) begin
            tick();
            if (int'($signed(dut.pending)) > peak) peak = int'($signed(dut.pending));
            if (!din_ready) saw_low = 1'b1;
            else if (saw_low) saw_high = 1'b1;
        end
        din_valid = 1'b0;
        check("t3_ready_dropped", saw_low, 1);
        check("t3_ready_returned", saw_high, 1);
        check("t3_peak_in_range", (peak > LIM) && (peak <= 2047), 1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("t3_flush_pending", int'($signed(dut.pending)), 0);
        check("t3_flush_busy", busy, 0);
        repeat (2) tick();

        // Accept +1 in the same cycle as an edge
        c0        = cnt;
        din_valid = 1'b1;
        din       = 9'd1;
        tick();
        tick();
        din_valid = 1'b0;
        check("t4_pending_after_edge", int'($signed(dut.pending)), 1);
        check("t4_busy", busy, 1);
        repeat (3) tick();
        check("t4_one_edge", cnt - c0, 1);
        check("t4_pending_held", int'($signed(dut.pending)), 1);
        tick();
        check("t4_pending_done", int'($signed(dut.pending)), 0);
        check("t4_busy_done", busy, 0);
        tick();
        check("t4_two_edges", cnt - c0, 2);

        // clr mid-HOLD with din_valid high
        din_valid = 1'b1;
        din       = 9'd21;
        tick();
        din_valid = 1'b0;
        tick();
        tick();
        check("t5_pending_before", int'($signed(dut.pending)), 20);
        clr       = 1'b1;
        din_valid = 1'b1;
        din       = 9'd5;
        #1;
        check("t5_ready_in_clr", din_ready, 0);
        tick();
        clr       = 1'b0;
        din_valid = 1'b0;
        check("t5_pending_clr", int'($signed(dut.pending)), 0);
        check("t5_busy_clr", busy, 0);
        c0 = cnt;
        repeat (10) tick();
        check("t5_no_edges", cnt - c0, 0);

        // Async reset mid-HOLD
        din_valid = 1'b1;
        din       = 9'd51;
        tick();
        din_valid = 1'b0;
        tick();
        tick();
        check("t6_pending_before", int'($signed(dut.pending)), 50);
        check("t6_dir_before", dir, 1);
        #1;
        rstn = 1'b0;
        #1;
        check("t6_async_quad", quad, 2'b00);
        check("t6_async_busy", busy, 0);
        check("t6_async_dir", dir, 0);
        repeat (2) tick();
        rstn = 1'b1;
        tick();
        din_valid = 1'b1;
        din       = 9'h1FF;
        tick();
        din_valid = 1'b0;
        tick();
        check("t6_dec_quad", quad, 2'b01);
        check("t6_dec_dir", dir, 0);
        check("t6_dec_busy", busy, 0);
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
